musicbox_mode_controller: RTL and testbench

Top-level mode sequencer for the music box. It takes the debounced UI command lines and music keys from the trigger smoothers and arbitrates them into one exclusive operating mode: idle/live, song 0, song 1, record or playback. It owns the recording buffer port toward the SDRAM controller, and it drives the key bitmap and song-player controls toward the audio path.

---
 rtl/musicbox_mode_controller_if.sv | 37 +++
 rtl/musicbox_mode_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_musicbox_mode_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/musicbox_mode_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : musicbox_mode_controller_if
// Description : Recording-buffer port between the music box mode controller
//               (master) and the SDRAM controller (slave).
//               Ports (master view):
//                 mem_req       out  request valid
//                 mem_write     out  1 = write, 0 = read
//                 mem_address   out  step address, ADDR_W bits
//                 mem_writeData out  key bitmap to store
//                 mem_ready     in   request accepted this cycle
//                 mem_readValid in   read data valid, one cycle
//                 mem_readData  in   returned key bitmap
// Revision    : 1.0 - initial release
// ============================================================================
interface musicbox_mode_controller_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [5:0]        mem_writeData;
    logic              mem_ready;
    logic              mem_readValid;
    logic [5:0]        mem_readData;

    modport master (
        output mem_req, mem_write, mem_address, mem_writeData,
        input  mem_ready, mem_readValid, mem_readData
    );

    modport slave (
        input  mem_req, mem_write, mem_address, mem_writeData,
        output mem_ready, mem_readValid, mem_readData
    );
endinterface
`default_nettype wire

// File: rtl/musicbox_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : musicbox_mode_controller
// Description : Arbitrates debounced UI commands into one exclusive mode
//               (idle/live, song 0, song 1, record, playback, drain), owns
//               the recording-buffer port and drives the key bitmap and the
//               song-player controls.
//               Ports:
//                 clock_50Mhz, reset_n          clock, async active-low reset
//                 musicKeys_s                   live key levels
//                 playSong0_s .. playRecording_s command levels
//                 stepTick, songDone            step strobe, song-end strobe
//                 mem                           recording buffer (master)
//                 mode, songStart, songStop, songSelect, activeKeys,
//                 recordingLength, overrun      status / audio-path controls
// Revision    : 1.0 - initial release
// ============================================================================
module musicbox_mode_controller #(
    parameter int ADDR_W = 16
) (
    input  wire                        clock_50Mhz,
    input  wire                        reset_n,
    input  wire  [5:0]                 musicKeys_s,
    input  wire                        playSong0_s,
    input  wire                        playSong1_s,
    input  wire                        makeRecording_s,
    input  wire                        playRecording_s,
    input  wire                        stepTick,
    input  wire                        songDone,
    musicbox_mode_controller_if.master mem,
    output logic [2:0]                 mode,
    output logic                       songStart,
    output logic                       songStop,
    output logic                       songSelect,
    output logic [5:0]                 activeKeys,
    output logic [ADDR_W:0]            recordingLength,
    output logic                       overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SONG0  = 3'd1,
        S_SONG1  = 3'd2,
        S_RECORD = 3'd3,
        S_PLAY   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cmd_prev;   // {playRecording, makeRecording, playSong1, playSong0}
    logic              r_req;
    logic              r_write;
    logic              r_rd_pend;    // read accepted, data not yet returned
    logic              r_pb_last;    // final playback step has returned
    logic [ADDR_W-1:0] r_addr;
    logic [5:0]        r_wdata;
    logic [5:0]        r_keys;
    logic [ADDR_W:0]   r_len;
    logic              r_overrun;
    logic              r_start;
    logic              r_stop;
    logic              r_sel;

    logic [3:0]        w_cmd;
    logic [3:0]        w_edge;
    logic              w_accept;
    logic              w_rvalid;
    logic              w_stop;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W:0]   w_len_acc;

    assign w_cmd      = {playRecording_s, makeRecording_s, playSong1_s, playSong0_s};
    assign w_edge     = w_cmd & ~r_cmd_prev;
    assign w_accept   = r_req & mem.mem_ready;
    assign w_rvalid   = r_rd_pend & mem.mem_readValid;
    assign w_addr_inc = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    // Stored-step count if the step at the current address completes now.
    assign w_len_acc  = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // Only the command that owns the running mode can stop it.
    always_comb begin
        w_stop = 1'b0;
        case (r_state)
            S_SONG0:  w_stop = w_edge[0];
            S_SONG1:  w_stop = w_edge[1];
            S_RECORD: w_stop = w_edge[2];
            S_PLAY:   w_stop = w_edge[3];
            default:  w_stop = 1'b0;
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cmd_prev <= '0;
            r_req      <= 1'b0;
            r_write    <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_pb_last  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_keys     <= '0;
            r_len      <= '0;
            r_overrun  <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_cmd_prev <= w_cmd;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_keys <= musicKeys_s;
                    if (w_edge[2]) begin
                        r_state   <= S_RECORD;
                        r_addr    <= '0;
                        r_overrun <= 1'b0;
                    end else if (w_edge[3] && (r_len != '0)) begin
                        r_state   <= S_PLAY;
                        r_addr    <= '0;
                        r_pb_last <= 1'b0;
                        r_keys    <= '0;
                    end else if (w_edge[0]) begin
                        r_state <= S_SONG0;
                        r_start <= 1'b1;
                        r_sel   <= 1'b0;
                        r_keys  <= '0;
                    end else if (w_edge[1]) begin
                        r_state <= S_SONG1;
                        r_start <= 1'b1;
                        r_sel   <= 1'b1;
                        r_keys  <= '0;
                    end
                end

                S_SONG0, S_SONG1: begin
                    r_keys <= '0;
                    if (songDone) begin
                        r_state <= S_IDLE;
                        r_keys  <= musicKeys_s;
                    end else if (w_stop) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b1;
                        r_keys  <= musicKeys_s;
                    end
                end

                S_RECORD: begin
                    r_keys <= musicKeys_s;
                    if (stepTick && r_req && !mem.mem_ready) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_accept) begin
                        r_addr <= w_addr_inc;
                        r_len  <= w_len_acc;
                    end
                    if (w_accept && (&r_addr)) begin
                        // Buffer full: the last slot was just written.
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (w_stop) begin
                        if (r_req && !mem.mem_ready) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end else if (stepTick && (!r_req || mem.mem_ready)) begin
                        // Address already advances on a same-cycle acceptance.
                        r_req   <= 1'b1;
                        r_write <= 1'b1;
                        r_wdata <= musicKeys_s;
                    end else if (w_accept) begin
                        r_req <= 1'b0;
                    end
                end

                S_PLAY: begin
                    if (w_accept) begin
                        r_req     <= 1'b0;
                        r_rd_pend <= 1'b1;
                    end
                    if (w_rvalid) begin
                        r_rd_pend <= 1'b0;
                        r_keys    <= mem.mem_readData;
                        r_addr    <= w_addr_inc;
                        if (w_len_acc == r_len) begin
                            r_pb_last <= 1'b1;
                        end
                    end
                    if (w_stop) begin
                        r_keys    <= '0;
                        r_pb_last <= 1'b0;
                        if (r_req || (r_rd_pend && !mem.mem_readValid)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_pb_last) begin
                        // Last step stays visible for one cycle before leaving.
                        r_state   <= S_IDLE;
                        r_pb_last <= 1'b0;
                        r_keys    <= '0;
                    end else if (stepTick && !r_req && !r_rd_pend) begin
                        r_req   <= 1'b1;
                        r_write <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    r_keys <= musicKeys_s;
                    if (w_accept) begin
                        r_req <= 1'b0;
                        if (r_write) begin
                            r_addr  <= w_addr_inc;
                            r_len   <= w_len_acc;
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_pend <= 1'b1;
                        end
                    end
                    // Returned read data is discarded.
                    if (w_rvalid) begin
                        r_rd_pend <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_req     <= 1'b0;
                    r_rd_pend <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req       = r_req;
    assign mem.mem_write     = r_write;
    assign mem.mem_address   = r_addr;
    assign mem.mem_writeData = r_wdata;

    assign mode            = r_state;
    assign songStart       = r_start;
    assign songStop        = r_stop;
    assign songSelect      = r_sel;
    assign activeKeys      = r_keys;
    assign recordingLength = r_len;
    assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_musicbox_mode_controller.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_musicbox_mode_controller
// Description : Self-checking bench for musicbox_mode_controller with a
//               behavioural memory model and scenario scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musicbox_mode_controller;
    localparam int AW        = 4;
    localparam int C_SONG0   = 0;
    localparam int C_SONG1   = 1;
    localparam int C_MAKEREC = 2;
    localparam int C_PLAYREC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [5:0]    keys = '0;
    logic [3:0]    cmd = '0;
    logic          tick = 1'b0;
    logic          song_done = 1'b0;
    logic [2:0]    mode;
    logic          song_start, song_stop, song_sel, ovr;
    logic [5:0]    act;
    logic [AW:0]   rec_len;

    musicbox_mode_controller_if #(.ADDR_W(AW)) mem_if ();

    musicbox_mode_controller #(.ADDR_W(AW)) dut (
        .clock_50Mhz     (clk),
        .reset_n         (rst_n),
        .musicKeys_s     (keys),
        .playSong0_s     (cmd[0]),
        .playSong1_s     (cmd[1]),
        .makeRecording_s (cmd[2]),
        .playRecording_s (cmd[3]),
        .stepTick        (tick),
        .songDone        (song_done),
        .mem             (mem_if),
        .mode            (mode),
        .songStart       (song_start),
        .songStop        (song_stop),
        .songSelect      (song_sel),
        .activeKeys      (act),
        .recordingLength (rec_len),
        .overrun         (ovr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    // Behavioural memory and transaction logs
    logic [5:0]  bmem [16];
    int          wr_a_q[$];
    int          wr_d_q[$];
    int          rd_a_q[$];
    int          rd_cnt = 0;
    int          rd_lat = 2;
    int          rd_a = 0;
    bit          last_rv = 1'b0;
    bit          hold_valid = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [5:0]  hold_data;
    logic        hold_write;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: log the transfer about to happen, clock, then update the memory model.
    task automatic step();
        logic rv_now;
        if (hold_valid) begin
            chk("hold_req",   32'(mem_if.mem_req),       32'd1);
            chk("hold_addr",  32'(mem_if.mem_address),   32'(hold_addr));
            chk("hold_data",  32'(mem_if.mem_writeData), 32'(hold_data));
            chk("hold_write", 32'(mem_if.mem_write),     32'(hold_write));
        end
        hold_valid = mem_if.mem_req && !mem_if.mem_ready;
        hold_addr  = mem_if.mem_address;
        hold_data  = mem_if.mem_writeData;
        hold_write = mem_if.mem_write;
        if (mem_if.mem_req && mem_if.mem_ready) begin
            if (mem_if.mem_write) begin
                bmem[mem_if.mem_address] = mem_if.mem_writeData;
                wr_a_q.push_back(int'(mem_if.mem_address));
                wr_d_q.push_back(int'(mem_if.mem_writeData));
            end else begin
                rd_a = int'(mem_if.mem_address);
                rd_a_q.push_back(rd_a);
                rd_cnt = rd_lat;
            end
        end
        rv_now = mem_if.mem_readValid;
        @(posedge clk);
        #1;
        last_rv = rv_now;
        tick = 1'b0;
        mem_if.mem_readValid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_if.mem_readValid = 1'b1;
                mem_if.mem_readData  = bmem[rd_a];
            end
        end
    endtask

    task automatic cmd_edge(input int which);
        step();
        cmd[which] = 1'b1;
        step();
        cmd[which] = 1'b0;
    endtask

    task automatic wait_rv(input string tag, input bit rnd_ready);
        int n;
        n = 0;
        last_rv = 1'b0;
        while (!last_rv && n < 60) begin
            if (rnd_ready) mem_if.mem_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        if (!last_rv) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_bus_idle(input string tag);
        int n;
        n = 0;
        while (mem_if.mem_req && n < 60) begin
            mem_if.mem_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        if (mem_if.mem_req) chk(tag, 32'd1, 32'd0);
    endtask

    task automatic check_zero_outputs(input string p);
        chk({p, "_mode"},  32'(mode), 0);
        chk({p, "_req"},   32'(mem_if.mem_req), 0);
        chk({p, "_write"}, 32'(mem_if.mem_write), 0);
        chk({p, "_addr"},  32'(mem_if.mem_address), 0);
        chk({p, "_wdata"}, 32'(mem_if.mem_writeData), 0);
        chk({p, "_start"}, 32'(song_start), 0);
        chk({p, "_stop"},  32'(song_stop), 0);
        chk({p, "_sel"},   32'(song_sel), 0);
        chk({p, "_keys"},  32'(act), 0);
        chk({p, "_len"},   32'(rec_len), 0);
        chk({p, "_ovr"},   32'(ovr), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat [3];
        logic [5:0] rdat [8];
        int n_steps;
        pat[0] = 6'd5; pat[1] = 6'd9; pat[2] = 6'd2;
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_readValid = 1'b0;
        mem_if.mem_readData  = '0;
        for (int i = 0; i < 16; i++) bmem[i] = '0;

        // ---- reset ----
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        // ---- simultaneous song0 + makeRecording: record wins ----
        step();
        cmd[C_SONG0] = 1'b1; cmd[C_MAKEREC] = 1'b1;
        step();
        cmd = '0;
        chk("prio_mode", 32'(mode), 3);
        chk("prio_ovr", 32'(ovr), 0);
        chk("prio_nostart", 32'(song_start), 0);
        cmd_edge(C_SONG1);
        chk("rec_ignore_song1", 32'(mode), 3);
        cmd_edge(C_MAKEREC);
        chk("rec_stop_idle", 32'(mode), 0);

        // ---- full-buffer recording with auto-stop ----
        wr_a_q.delete(); wr_d_q.delete();
        mem_if.mem_ready = 1'b1;
        cmd_edge(C_MAKEREC);
        for (int k = 1; k <= 20; k++) begin
            keys = 6'(k);
            tick = 1'b1;
            step();
            if (k == 3) chk("rec_live_keys", 32'(act), 3);
            repeat ($urandom_range(0, 1)) step();
        end
        repeat (3) step();
        chk("full_nwrites", 32'(wr_a_q.size()), 16);
        for (int i = 0; i < wr_a_q.size() && i < 16; i++) begin
            chk("full_waddr", 32'(wr_a_q[i]), 32'(i));
            chk("full_wdata", 32'(wr_d_q[i]), 32'(i + 1));
        end
        chk("full_mode", 32'(mode), 0);
        chk("full_len", 32'(rec_len), 16);
        chk("full_req", 32'(mem_if.mem_req), 0);

        // ---- record 5,9,2 then play back ----
        wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete();
        cmd_edge(C_MAKEREC);
        for (int i = 0; i < 3; i++) begin
            keys = pat[i];
            tick = 1'b1;
            step(); step(); step();
        end
        keys = '0;
        cmd_edge(C_MAKEREC);
        chk("pb3_len", 32'(rec_len), 3);
        chk("pb3_nwrites", 32'(wr_a_q.size()), 3);
        rd_lat = 2;
        cmd_edge(C_PLAYREC);
        chk("pb3_mode", 32'(mode), 4);
        chk("pb3_keys0", 32'(act), 0);
        keys = 6'h2A;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            wait_rv("pb3_rv_timeout", 1'b0);
            chk("pb3_keys", 32'(act), 32'(pat[i]));
        end
        step();
        chk("pb3_end_mode", 32'(mode), 0);
        chk("pb3_end_keys", 32'(act), 0);
        step();
        chk("pb3_live_keys", 32'(act), 32'h2A);
        chk("pb3_nreads", 32'(rd_a_q.size()), 3);
        for (int i = 0; i < rd_a_q.size() && i < 3; i++) chk("pb3_raddr", 32'(rd_a_q[i]), 32'(i));

        // ---- overrun and drain ----
        wr_a_q.delete(); wr_d_q.delete();
        mem_if.mem_ready = 1'b0;
        cmd_edge(C_MAKEREC);
        chk("ovr_clear", 32'(ovr), 0);
        keys = 6'd7;
        tick = 1'b1; step();
        step();
        tick = 1'b1; step();
        chk("ovr_set", 32'(ovr), 1);
        cmd_edge(C_MAKEREC);
        chk("drain_mode", 32'(mode), 5);
        chk("drain_req", 32'(mem_if.mem_req), 1);
        repeat (3) step();
        chk("drain_wait", 32'(mode), 5);
        mem_if.mem_ready = 1'b1;
        step();
        chk("drain_done", 32'(mode), 0);
        chk("drain_len", 32'(rec_len), 1);
        chk("drain_req0", 32'(mem_if.mem_req), 0);
        chk("drain_ovr_sticky", 32'(ovr), 1);
        chk("drain_nwrites", 32'(wr_a_q.size()), 1);
        if (wr_a_q.size() > 0) chk("drain_wdata", 32'(wr_d_q[0]), 7);

        // ---- songs ----
        keys = 6'h15;
        cmd_edge(C_SONG1);
        chk("s1_mode", 32'(mode), 2);
        chk("s1_start", 32'(song_start), 1);
        chk("s1_sel", 32'(song_sel), 1);
        chk("s1_keys", 32'(act), 0);
        step();
        chk("s1_start_pulse", 32'(song_start), 0);
        cmd_edge(C_SONG1);
        chk("s1_stop", 32'(song_stop), 1);
        chk("s1_stop_mode", 32'(mode), 0);
        chk("s1_stop_keys", 32'(act), 32'h15);
        step();
        chk("s1_stop_pulse", 32'(song_stop), 0);
        cmd_edge(C_SONG1);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        chk("s1_done_mode", 32'(mode), 0);
        chk("s1_done_nostop", 32'(song_stop), 0);
        cmd_edge(C_SONG0);
        chk("s0_mode", 32'(mode), 1);
        chk("s0_sel", 32'(song_sel), 0);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        chk("s0_done_mode", 32'(mode), 0);

        // ---- asynchronous reset mid-playback ----
        mem_if.mem_ready = 1'b0;
        cmd_edge(C_PLAYREC);
        chk("arst_pb_mode", 32'(mode), 4);
        tick = 1'b1;
        step();
        chk("arst_req", 32'(mem_if.mem_req), 1);
        #2 rst_n = 1'b0;
        #0.5;
        check_zero_outputs("arst");
        #0.5 rst_n = 1'b1;
        hold_valid = 1'b0;
        rd_cnt = 0;
        cmd[C_PLAYREC] = 1'b1;
        step();
        cmd[C_PLAYREC] = 1'b0;
        chk("arst_play_ignored", 32'(mode), 0);
        chk("arst_len", 32'(rec_len), 0);

        // ---- randomized record / playback rounds ----
        for (int r = 0; r < 6; r++) begin
            n_steps = $urandom_range(1, 6);
            rd_lat = $urandom_range(1, 3);
            wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete();
            cmd_edge(C_MAKEREC);
            for (int k = 0; k < n_steps; k++) begin
                wait_bus_idle("rnd_wbusy_timeout");
                rdat[k] = 6'($urandom);
                keys = rdat[k];
                tick = 1'b1;
                mem_if.mem_ready = 1'($urandom_range(0, 1));
                step();
            end
            wait_bus_idle("rnd_wdone_timeout");
            cmd_edge(C_MAKEREC);
            chk("rnd_rec_mode", 32'(mode), 0);
            chk("rnd_len", 32'(rec_len), 32'(n_steps));
            chk("rnd_ovr", 32'(ovr), 0);
            chk("rnd_nwrites", 32'(wr_a_q.size()), 32'(n_steps));
            for (int i = 0; i < wr_a_q.size() && i < n_steps; i++) begin
                chk("rnd_waddr", 32'(wr_a_q[i]), 32'(i));
                chk("rnd_wdata", 32'(wr_d_q[i]), 32'(rdat[i]));
            end
            cmd_edge(C_PLAYREC);
            chk("rnd_pb_mode", 32'(mode), 4);
            for (int k = 0; k < n_steps; k++) begin
                keys = 6'($urandom);
                tick = 1'b1;
                mem_if.mem_ready = 1'($urandom_range(0, 1));
                step();
                wait_rv("rnd_rv_timeout", 1'b1);
                chk("rnd_pb_keys", 32'(act), 32'(rdat[k]));
            end
            step();
            chk("rnd_pb_end", 32'(mode), 0);
            chk("rnd_nreads", 32'(rd_a_q.size()), 32'(n_steps));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
